// File: rtl/mips_axi_lite_master.sv
// Single-outstanding bridge from the MIPS core valid/ready memory port to an AXI4-Lite master.
// Define MIPS_AXI_TIMEOUT_EN to add the bus watchdog and the sticky mips_bus_timeout output.
module mips_axi_lite_master #(
   parameter logic [31:0] ADDR_OFFSET    = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        mips_cpu_clk,
   input  logic        mips_axi_if_resetn,
   input  logic        mem_req_valid,
   output logic        mem_req_ready,
   input  logic        mem_req_wen,
   input  logic [31:0] mem_req_addr,
   input  logic [31:0] mem_req_wdata,
   input  logic [3:0]  mem_req_wstrb,
   output logic        mem_rsp_valid,
   input  logic        mem_rsp_ready,
   output logic [31:0] mem_rsp_rdata,
   output logic        mem_rsp_err,
   output logic [31:0] axi_araddr,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   input  logic [31:0] axi_rdata,
   input  logic [1:0]  axi_rresp,
   input  logic        axi_rvalid,
   output logic        axi_rready,
   output logic [31:0] axi_awaddr,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic [31:0] axi_wdata,
   output logic [3:0]  axi_wstrb,
   output logic        axi_wvalid,
   input  logic        axi_wready,
   input  logic [1:0]  axi_bresp,
   input  logic        axi_bvalid,
   output logic        axi_bready,
   output logic [31:0] mips_perf_bus_cnt
`ifdef MIPS_AXI_TIMEOUT_EN
   ,
   output logic        mips_bus_timeout
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ADDR = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR_REQ  = 3'd3,
      S_WR_RESP = 3'd4,
      S_RSP     = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   state_t      w_fin_state;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_aw_done;
   logic        r_w_done;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_perf_cnt;

   logic w_accept;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_r_hs;
   logic w_b_hs;
   logic w_wr_both;
   logic w_busy;
   logic w_discard;
   logic w_to_fire;
   logic w_rsp_valid;
   logic w_rresp_err;
   logic w_bresp_err;

   assign w_accept    = (r_state == S_IDLE) & mem_req_valid;
   assign w_aw_hs     = (r_state == S_WR_REQ) & ~r_aw_done & axi_awready;
   assign w_w_hs      = (r_state == S_WR_REQ) & ~r_w_done & axi_wready;
   assign w_wr_both   = (r_state == S_WR_REQ) & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
   assign w_r_hs      = (r_state == S_RD_DATA) & axi_rvalid;
   assign w_b_hs      = (r_state == S_WR_RESP) & axi_bvalid;
   assign w_busy      = (r_state == S_RD_ADDR) | (r_state == S_RD_DATA) |
                        (r_state == S_WR_REQ)  | (r_state == S_WR_RESP);
   // EXOKAY (2'b01) is a success; only SLVERR/DECERR flag an error.
   assign w_rresp_err = (axi_rresp == 2'b10) | (axi_rresp == 2'b11);
   assign w_bresp_err = (axi_bresp == 2'b10) | (axi_bresp == 2'b11);

`ifdef MIPS_AXI_TIMEOUT_EN
   localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] r_wdog;
   logic        r_to_fired;
   logic        r_to_rsp;
   logic        r_timeout;

   // A watchdog response is delivered early; the late AXI completion is then dropped.
   assign w_to_fire   = w_busy & ~r_to_fired & (r_wdog == LP_TO_LAST) & ~w_r_hs & ~w_b_hs;
   assign w_discard   = r_to_fired;
   assign w_rsp_valid = (r_state == S_RSP) | r_to_rsp;
   assign w_fin_state = (~r_to_fired | (r_to_rsp & ~mem_rsp_ready)) ? S_RSP : S_IDLE;
   assign mips_bus_timeout = r_timeout;

   // Watchdog counter, early-response tracking and sticky timeout flag.
   always_ff @(posedge mips_cpu_clk or negedge mips_axi_if_resetn) begin
      if (!mips_axi_if_resetn) begin
         r_wdog     <= 32'd0;
         r_to_fired <= 1'b0;
         r_to_rsp   <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wdog     <= 32'd0;
            r_to_fired <= 1'b0;
         end else if (w_to_fire) begin
            r_to_fired <= 1'b1;
            r_timeout  <= 1'b1;
         end else if (w_busy && !r_to_fired) begin
            r_wdog <= r_wdog + 32'd1;
         end
         if (w_to_fire) begin
            r_to_rsp <= 1'b1;
         end else if (r_to_rsp && mem_rsp_ready) begin
            r_to_rsp <= 1'b0;
         end
      end
   end
`else
   assign w_to_fire   = 1'b0;
   assign w_discard   = 1'b0;
   assign w_rsp_valid = (r_state == S_RSP);
   assign w_fin_state = S_RSP;
`endif

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (mem_req_valid) begin
               w_state_nxt = mem_req_wen ? S_WR_REQ : S_RD_ADDR;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RD_ADDR: begin
            if (axi_arready) begin
               w_state_nxt = S_RD_DATA;
            end else begin
               w_state_nxt = S_RD_ADDR;
            end
         end
         S_RD_DATA: begin
            if (axi_rvalid) begin
               w_state_nxt = w_fin_state;
            end else begin
               w_state_nxt = S_RD_DATA;
            end
         end
         S_WR_REQ: begin
            if (w_wr_both) begin
               w_state_nxt = S_WR_RESP;
            end else begin
               w_state_nxt = S_WR_REQ;
            end
         end
         S_WR_RESP: begin
            if (axi_bvalid) begin
               w_state_nxt = w_fin_state;
            end else begin
               w_state_nxt = S_WR_RESP;
            end
         end
         S_RSP: begin
            if (mem_rsp_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_RSP;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, request payload, per-channel write flags, response data and busy counter.
   always_ff @(posedge mips_cpu_clk or negedge mips_axi_if_resetn) begin
      if (!mips_axi_if_resetn) begin
         r_state    <= S_IDLE;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_wstrb    <= 4'd0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         r_rdata    <= 32'd0;
         r_err      <= 1'b0;
         r_perf_cnt <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_addr    <= (mem_req_addr + ADDR_OFFSET) & ~32'h0000_0003;
            r_wdata   <= mem_req_wdata;
            r_wstrb   <= mem_req_wstrb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
         end
         if (w_to_fire) begin
            r_rdata <= 32'hDEAD_BEEF;
            r_err   <= 1'b1;
         end else if (w_r_hs && !w_discard) begin
            r_rdata <= axi_rdata;
            r_err   <= w_rresp_err;
         end else if (w_b_hs && !w_discard) begin
            r_rdata <= 32'd0;
            r_err   <= w_bresp_err;
         end
         if (r_state != S_IDLE) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
         end
      end
   end

   // Ready is held low while reset is asserted even though the state already reads IDLE.
   assign mem_req_ready     = (r_state == S_IDLE) & mips_axi_if_resetn;
   assign mem_rsp_valid     = w_rsp_valid;
   assign mem_rsp_rdata     = r_rdata;
   assign mem_rsp_err       = r_err;
   assign axi_araddr        = r_addr;
   assign axi_arvalid       = (r_state == S_RD_ADDR);
   assign axi_rready        = (r_state == S_RD_DATA);
   assign axi_awaddr        = r_addr;
   assign axi_awvalid       = (r_state == S_WR_REQ) & ~r_aw_done;
   assign axi_wdata         = r_wdata;
   assign axi_wstrb         = r_wstrb;
   assign axi_wvalid        = (r_state == S_WR_REQ) & ~r_w_done;
   assign axi_bready        = (r_state == S_WR_RESP);
   assign mips_perf_bus_cnt = r_perf_cnt;

endmodule

// File: tb/tb_mips_axi_lite_master.sv
// Directed self-checking bench for mips_axi_lite_master (ADDR_OFFSET = 32'h4000_0000).
module tb_mips_axi_lite_master;

   logic        clk;
   logic        rst_n;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
   logic [31:0] mem_rsp_rdata;
   logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata, perf_cnt;
   logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
   logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
   logic        axi_bvalid, axi_bready;
   logic [1:0]  axi_rresp, axi_bresp;
   logic [3:0]  axi_wstrb;
`ifdef MIPS_AXI_TIMEOUT_EN
   logic        bus_timeout;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mips_axi_lite_master #(
      .ADDR_OFFSET(32'h4000_0000),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .mips_cpu_clk(clk), .mips_axi_if_resetn(rst_n),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
      .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .mips_perf_bus_cnt(perf_cnt)
`ifdef MIPS_AXI_TIMEOUT_EN
      , .mips_bus_timeout(bus_timeout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Zero-wait read: accept, AR, R, response at cycle 3, accepted immediately.
   task automatic rd0(input logic [31:0] addr, input logic [31:0] exp_addr,
                      input logic [31:0] data, input logic [1:0] resp, input logic exp_err);
      mem_req_valid = 1'b1; mem_req_wen = 1'b0; mem_req_addr = addr;
      check_eq("rd0_req_ready", 32'(mem_req_ready), 32'd1);
      tick();
      mem_req_valid = 1'b0;
      check_eq("rd0_arvalid", 32'(axi_arvalid), 32'd1);
      check_eq("rd0_araddr", axi_araddr, exp_addr);
      axi_arready = 1'b1;
      tick();
      axi_arready = 1'b0;
      check_eq("rd0_rready", 32'(axi_rready), 32'd1);
      check_eq("rd0_rsp_early", 32'(mem_rsp_valid), 32'd0);
      axi_rvalid = 1'b1; axi_rdata = data; axi_rresp = resp;
      tick();
      axi_rvalid = 1'b0;
      check_eq("rd0_rsp_valid", 32'(mem_rsp_valid), 32'd1);
      check_eq("rd0_rdata", mem_rsp_rdata, data);
      check_eq("rd0_err", 32'(mem_rsp_err), 32'(exp_err));
      check_eq("rd0_busy_ready", 32'(mem_req_ready), 32'd0);
      mem_rsp_ready = 1'b1;
      tick();
      mem_rsp_ready = 1'b0;
      check_eq("rd0_rsp_done", 32'(mem_rsp_valid), 32'd0);
      check_eq("rd0_idle_ready", 32'(mem_req_ready), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL tb_time_limit: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      mem_req_valid = 1'b0; mem_req_wen = 1'b0; mem_req_addr = 32'd0;
      mem_req_wdata = 32'd0; mem_req_wstrb = 4'd0; mem_rsp_ready = 1'b0;
      axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = 32'd0; axi_rresp = 2'd0;
      axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'd0;
      tick(); tick();
      check_eq("rst_req_ready", 32'(mem_req_ready), 32'd0);
      check_eq("rst_arvalid", 32'(axi_arvalid), 32'd0);
      check_eq("rst_awvalid", 32'(axi_awvalid), 32'd0);
      check_eq("rst_araddr", axi_araddr, 32'd0);
      check_eq("rst_rdata", mem_rsp_rdata, 32'd0);
      check_eq("rst_perf", perf_cnt, 32'd0);
      rst_n = 1'b1;
      tick();
      check_eq("post_rst_ready", 32'(mem_req_ready), 32'd1);

      // Offset plus word alignment: 0x106 + 0x4000_0000 -> 0x4000_0104.
      rd0(32'h0000_0106, 32'h4000_0104, 32'h1234_5678, 2'b00, 1'b0);
      check_eq("perf_rd", perf_cnt, 32'd3);

      // Write: W handshakes at cycle 1, AW three cycles later at cycle 4.
      mem_req_valid = 1'b1; mem_req_wen = 1'b1; mem_req_addr = 32'h0000_0020;
      mem_req_wdata = 32'hA5A5_A5A5; mem_req_wstrb = 4'b0011;
      tick();
      mem_req_valid = 1'b0;
      check_eq("wr_awvalid_c1", 32'(axi_awvalid), 32'd1);
      check_eq("wr_wvalid_c1", 32'(axi_wvalid), 32'd1);
      check_eq("wr_awaddr", axi_awaddr, 32'h4000_0020);
      check_eq("wr_wdata", axi_wdata, 32'hA5A5_A5A5);
      check_eq("wr_wstrb", 32'(axi_wstrb), 32'h3);
      axi_wready = 1'b1;
      tick();
      axi_wready = 1'b0;
      check_eq("wr_wvalid_drop", 32'(axi_wvalid), 32'd0);
      check_eq("wr_awvalid_hold", 32'(axi_awvalid), 32'd1);
      tick();
      check_eq("wr_awvalid_c3", 32'(axi_awvalid), 32'd1);
      check_eq("wr_awaddr_c3", axi_awaddr, 32'h4000_0020);
      tick();
      check_eq("wr_awvalid_c4", 32'(axi_awvalid), 32'd1);
      check_eq("wr_bready_early", 32'(axi_bready), 32'd0);
      axi_awready = 1'b1;
      tick();
      axi_awready = 1'b0;
      check_eq("wr_awvalid_done", 32'(axi_awvalid), 32'd0);
      check_eq("wr_bready", 32'(axi_bready), 32'd1);
      axi_bvalid = 1'b1; axi_bresp = 2'b00;
      tick();
      axi_bvalid = 1'b0;
      check_eq("wr_bready_once", 32'(axi_bready), 32'd0);
      check_eq("wr_rsp_valid", 32'(mem_rsp_valid), 32'd1);
      check_eq("wr_rsp_err", 32'(mem_rsp_err), 32'd0);
      check_eq("wr_rsp_rdata", mem_rsp_rdata, 32'd0);
      mem_rsp_ready = 1'b1;
      tick();
      mem_rsp_ready = 1'b0;
      check_eq("wr_idle_ready", 32'(mem_req_ready), 32'd1);
      check_eq("perf_wr", perf_cnt, 32'd9);

      // Read with arready stalled for 5 cycles, SLVERR response, then a held response.
      mem_req_valid = 1'b1; mem_req_wen = 1'b0; mem_req_addr = 32'h0000_0200;
      tick();
      mem_req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_eq("stall_arvalid", 32'(axi_arvalid), 32'd1);
         check_eq("stall_araddr", axi_araddr, 32'h4000_0200);
         tick();
      end
      check_eq("stall_arvalid_last", 32'(axi_arvalid), 32'd1);
      axi_arready = 1'b1;
      tick();
      axi_arready = 1'b0;
      axi_rvalid = 1'b1; axi_rdata = 32'hCAFE_0001; axi_rresp = 2'b10;
      tick();
      axi_rvalid = 1'b0; axi_rresp = 2'b00;
      // Core keeps a new request pending while it is not accepting the response.
      mem_req_valid = 1'b1; mem_req_wen = 1'b1; mem_req_addr = 32'h0000_0300;
      for (int i = 0; i < 4; i++) begin
         check_eq("hold_rsp_valid", 32'(mem_rsp_valid), 32'd1);
         check_eq("hold_rdata", mem_rsp_rdata, 32'hCAFE_0001);
         check_eq("hold_err", 32'(mem_rsp_err), 32'd1);
         check_eq("hold_req_ready", 32'(mem_req_ready), 32'd0);
         check_eq("hold_no_ar_aw", 32'({axi_arvalid, axi_awvalid}), 32'd0);
         tick();
      end
      mem_req_valid = 1'b0;
      mem_rsp_ready = 1'b1;
      tick();
      mem_rsp_ready = 1'b0;
      check_eq("hold_released", 32'(mem_rsp_valid), 32'd0);
      check_eq("hold_idle_ready", 32'(mem_req_ready), 32'd1);
      check_eq("perf_stall", perf_cnt, 32'd21);

      // EXOKAY is not an error; address wraps modulo 2^32; DECERR is an error.
      rd0(32'hC000_0003, 32'h0000_0000, 32'h0BAD_F00D, 2'b01, 1'b0);
      rd0(32'h0000_0007, 32'h4000_0004, 32'h7777_0000, 2'b11, 1'b1);
      check_eq("perf_more", perf_cnt, 32'd27);

      // Asynchronous reset while waiting in RD_DATA.
      mem_req_valid = 1'b1; mem_req_wen = 1'b0; mem_req_addr = 32'h0000_0040;
      tick();
      mem_req_valid = 1'b0;
      axi_arready = 1'b1;
      tick();
      axi_arready = 1'b0;
      check_eq("mid_rready", 32'(axi_rready), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_rready", 32'(axi_rready), 32'd0);
      check_eq("mid_rst_araddr", axi_araddr, 32'd0);
      check_eq("mid_rst_req_ready", 32'(mem_req_ready), 32'd0);
      check_eq("mid_rst_perf", perf_cnt, 32'd0);
      check_eq("mid_rst_rsp", 32'(mem_rsp_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("after_rst_ready", 32'(mem_req_ready), 32'd1);
      check_eq("after_rst_rsp", 32'(mem_rsp_valid), 32'd0);
      check_eq("after_rst_rready", 32'(axi_rready), 32'd0);

`ifdef MIPS_AXI_TIMEOUT_EN
      // Slave accepts AR but withholds R beyond the watchdog limit.
      check_eq("to_flag_clear", 32'(bus_timeout), 32'd0);
      mem_req_valid = 1'b1; mem_req_wen = 1'b0; mem_req_addr = 32'h0000_0080;
      tick();
      mem_req_valid = 1'b0;
      axi_arready = 1'b1;
      tick();
      axi_arready = 1'b0;
      begin
         int waited;
         waited = 0;
         while (!mem_rsp_valid && waited < 40) begin
            tick();
            waited++;
         end
         check_eq("to_rsp_seen", 32'(mem_rsp_valid), 32'd1);
         check_eq("to_not_early", 32'(waited >= 10), 32'd1);
      end
      check_eq("to_err", 32'(mem_rsp_err), 32'd1);
      check_eq("to_rdata", mem_rsp_rdata, 32'hDEAD_BEEF);
      check_eq("to_flag", 32'(bus_timeout), 32'd1);
      check_eq("to_req_ready", 32'(mem_req_ready), 32'd0);
      mem_rsp_ready = 1'b1;
      tick();
      mem_rsp_ready = 1'b0;
      check_eq("to_rsp_gone", 32'(mem_rsp_valid), 32'd0);
      check_eq("to_still_busy", 32'(mem_req_ready), 32'd0);
      axi_rvalid = 1'b1; axi_rdata = 32'h1111_1111; axi_rresp = 2'b00;
      tick();
      axi_rvalid = 1'b0;
      check_eq("to_late_ready", 32'(mem_req_ready), 32'd1);
      check_eq("to_late_no_rsp", 32'(mem_rsp_valid), 32'd0);
      check_eq("to_rdata_kept", mem_rsp_rdata, 32'hDEAD_BEEF);
      check_eq("to_flag_sticky", 32'(bus_timeout), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
